// File: rtl/fetch_unit_pkg.sv
// Shared core package: reset/bubble constants, opcode constants and fetch-stage
// types used by the instruction fetch unit.
package fetch_unit_pkg;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: holds, advances by 4 (wrapping) or loads a word-aligned
// redirect target, with redirect winning over advance.
module fetch_unit_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [29:0] target_word_i,
  input  logic        advance_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)         pc_d = {target_word_i, 2'b00};
    else if (advance_i) pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory, fills IF/ID, parks a
// response in a one-entry buffer under stall and drains stale requests on redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_sel,
  input  logic [31:0] target_pc,
  input  logic        stall,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        flush_id_ex,
  output logic        misalign_err
);

  localparam if_id_t BUBBLE = '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};

  fetch_state_e state_q, state_d;
  if_id_t       ifid_q, ifid_d;
  if_id_t       hold_q, hold_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic         misalign_q, misalign_d;
  logic         advance;
  logic [31:0]  pc;

  fetch_unit_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (pc_sel),
    .target_word_i(target_pc[31:2]),
    .advance_i    (advance),
    .pc_o         (pc)
  );

  always_comb begin
    state_d      = state_q;
    ifid_d       = ifid_q;
    hold_d       = hold_q;
    drain_addr_d = drain_addr_q;
    advance      = 1'b0;
    misalign_d   = misalign_q | (pc_sel & (target_pc[1:0] != 2'b00));

    if (pc_sel) begin
      // Redirect beats stall everywhere; an unanswered request must still be drained.
      ifid_d = '{pc: pc, instr: NOP_INSTR, valid: 1'b0};
      hold_d = BUBBLE;
      if (state_q == FETCH && !imem_ready) begin
        state_d      = DRAIN;
        drain_addr_d = pc;
      end else if (state_q == DRAIN && !imem_ready) begin
        state_d = DRAIN;
      end else begin
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            advance = 1'b1;
            if (stall) begin
              hold_d  = '{pc: pc, instr: imem_rdata, valid: 1'b1};
              state_d = HOLD;
            end else begin
              ifid_d = '{pc: pc, instr: imem_rdata, valid: 1'b1};
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_d  = hold_q;
            hold_d  = BUBBLE;
            state_d = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ready) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      ifid_q       <= BUBBLE;
      hold_q       <= BUBBLE;
      drain_addr_q <= 32'h0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ifid_q       <= ifid_d;
      hold_q       <= hold_d;
      drain_addr_q <= drain_addr_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_req     = !rst && (state_q != HOLD);
  assign imem_addr    = (state_q == DRAIN) ? drain_addr_q : pc;
  assign flush_id_ex  = pc_sel && !rst;
  assign if_id_pc     = ifid_q.pc;
  assign if_id_instr  = ifid_q.instr;
  assign if_id_valid  = ifid_q.valid;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns {8'hA5, addr[23:0]} for any address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_sel;
  logic [31:0] target_pc;
  logic        stall;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        flush_id_ex;
  logic        misalign_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_rdata = {8'hA5, imem_addr[23:0]};

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_sel      (pc_sel),
    .target_pc   (target_pc),
    .stall       (stall),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .flush_id_ex (flush_id_ex),
    .misalign_err(misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; pc_sel = 1'b0; stall = 1'b0; target_pc = 32'h0; imem_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_sel = 1'b1; target_pc = 32'h0000_0123; stall = 1'b0; imem_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (flush_id_ex !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush_id_ex); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
    n_cmp++; if (if_id_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr: got %h want 00000013", if_id_instr); end
    n_cmp++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ifid_pc: got %h want 0", if_id_pc); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
    pc_sel = 1'b0; target_pc = 32'h0; rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL release_fetch: req %b addr %h want 1 00000000", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = 32'(i * 4);
      n_cmp++;
      if (if_id_pc !== exp_pc || if_id_valid !== 1'b1 || if_id_instr !== {8'hA5, exp_pc[23:0]}) begin
        n_fail++; $display("FAIL stream_%0d: pc %h instr %h v %b want %h %h 1", i, if_id_pc, if_id_instr, if_id_valid, exp_pc, {8'hA5, exp_pc[23:0]});
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    tick(); tick();
    stall = 1'b1;
    #1;
    n_cmp++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_pre: addr %h req %b want 00000008 1", imem_addr, imem_req); end
    tick();
    n_cmp++; if (imem_req !== 1'b0 || if_id_pc !== 32'h4) begin n_fail++; $display("FAIL stall_hold_enter: req %b ifid %h want 0 00000004", imem_req, if_id_pc); end
    tick(); tick();
    n_cmp++; if (if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_ifid_frozen: pc %h v %b want 00000004 1", if_id_pc, if_id_valid); end
    stall = 1'b0;
    tick();
    n_cmp++; if (if_id_pc !== 32'h8 || if_id_instr !== 32'hA500_0008 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release: pc %h instr %h v %b want 00000008 a5000008 1", if_id_pc, if_id_instr, if_id_valid); end
    n_cmp++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_resume_addr: addr %h req %b want 0000000c 1", imem_addr, imem_req); end
    tick();
    n_cmp++; if (if_id_pc !== 32'hC) begin n_fail++; $display("FAIL stall_next: pc %h want 0000000c", if_id_pc); end
  endtask

  task automatic test_stall_noready();
    imem_ready = 1'b0; stall = 1'b1;
    tick(); tick();
    n_cmp++; if (if_id_pc !== 32'hC || imem_addr !== 32'h10 || imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_noready: ifid %h addr %h req %b want 0000000c 00000010 1", if_id_pc, imem_addr, imem_req); end
    imem_ready = 1'b1; stall = 1'b0;
    tick();
    n_cmp++; if (if_id_pc !== 32'h10) begin n_fail++; $display("FAIL stall_noready_resume: pc %h want 00000010", if_id_pc); end
  endtask

  task automatic test_redirect_stall();
    pc_sel = 1'b1; target_pc = 32'h100; stall = 1'b1;
    #1;
    n_cmp++; if (flush_id_ex !== 1'b1) begin n_fail++; $display("FAIL redir_flush: got %b want 1", flush_id_ex); end
    tick();
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin n_fail++; $display("FAIL redir_bubble: v %b instr %h want 0 00000013", if_id_valid, if_id_instr); end
    n_cmp++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin n_fail++; $display("FAIL redir_addr: addr %h req %b want 00000100 1", imem_addr, imem_req); end
    pc_sel = 1'b0; stall = 1'b0;
    #1;
    n_cmp++; if (flush_id_ex !== 1'b0) begin n_fail++; $display("FAIL redir_flush_drop: got %b want 0", flush_id_ex); end
    tick();
    n_cmp++; if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL redir_first: pc %h v %b want 00000100 1", if_id_pc, if_id_valid); end
  endtask

  task automatic test_drain();
    apply_reset();
    tick(); tick(); tick(); tick();
    n_cmp++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL drain_setup: addr %h want 00000010", imem_addr); end
    imem_ready = 1'b0; pc_sel = 1'b1; target_pc = 32'h200;
    tick();
    n_cmp++; if (imem_addr !== 32'h10 || imem_req !== 1'b1 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_enter: addr %h req %b v %b want 00000010 1 0", imem_addr, imem_req, if_id_valid); end
    pc_sel = 1'b0;
    tick();
    n_cmp++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL drain_hold_addr: addr %h want 00000010", imem_addr); end
    imem_ready = 1'b1;
    tick();
    n_cmp++; if (imem_addr !== 32'h200 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_done: addr %h v %b want 00000200 0", imem_addr, if_id_valid); end
    tick();
    n_cmp++; if (if_id_pc !== 32'h200 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL drain_first: pc %h v %b want 00000200 1", if_id_pc, if_id_valid); end
  endtask

  task automatic test_last_wins();
    imem_ready = 1'b0; pc_sel = 1'b1; target_pc = 32'h400;
    tick();
    target_pc = 32'h500;
    tick();
    n_cmp++; if (imem_addr !== 32'h204) begin n_fail++; $display("FAIL lastwin_drain_addr: addr %h want 00000204", imem_addr); end
    pc_sel = 1'b0; imem_ready = 1'b1;
    tick();
    n_cmp++; if (imem_addr !== 32'h500) begin n_fail++; $display("FAIL lastwin_target: addr %h want 00000500", imem_addr); end
    tick();
    n_cmp++; if (if_id_pc !== 32'h500 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL lastwin_first: pc %h v %b want 00000500 1", if_id_pc, if_id_valid); end
  endtask

  task automatic test_misalign_wrap();
    pc_sel = 1'b1; target_pc = 32'h202;
    tick();
    n_cmp++; if (misalign_err !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL misalign_set: err %b addr %h want 1 00000200", misalign_err, imem_addr); end
    pc_sel = 1'b0;
    tick(); tick();
    n_cmp++; if (misalign_err !== 1'b1 || if_id_pc !== 32'h204) begin n_fail++; $display("FAIL misalign_sticky: err %b ifid %h want 1 00000204", misalign_err, if_id_pc); end
    pc_sel = 1'b1; target_pc = 32'hFFFF_FFFC;
    tick();
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_target: addr %h want fffffffc", imem_addr); end
    pc_sel = 1'b0;
    tick();
    n_cmp++; if (if_id_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_advance: ifid %h addr %h want fffffffc 00000000", if_id_pc, imem_addr); end
    n_cmp++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_persist: got %b want 1", misalign_err); end
    apply_reset();
    n_cmp++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %b want 0", misalign_err); end
  endtask

  task automatic test_reset_in_hold();
    apply_reset();
    tick(); tick();
    stall = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL hold_reset: v %b pc %h req %b addr %h want 0 0 0 0", if_id_valid, if_id_pc, imem_req, imem_addr); end
    stall = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (if_id_pc !== 32'h0 || if_id_instr !== 32'hA500_0000 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL hold_reset_discard: pc %h instr %h v %b want 0 a5000000 1", if_id_pc, if_id_instr, if_id_valid); end
  endtask

  initial begin
    rst = 1'b1; pc_sel = 1'b0; target_pc = 32'h0; stall = 1'b0; imem_ready = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_stall_noready();
    test_redirect_stall();
    test_drain();
    test_last_wins();
    test_misalign_wrap();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble inserted into IF/ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pc_sel  input  1  redirect request from EX-stage branch/jump controller; 1 = take target.
REQ-006 target_pc  input  32  redirect address (EX ALU result).
REQ-007 stall  input  1  hazard unit hold request for IF/ID.
REQ-008 imem_addr  output  32  instruction memory word address.
REQ-009 imem_req  output  1  fetch request; addr held stable while req=1 and ready=0.
REQ-010 imem_ready  input  1  response valid this cycle; imem_rdata sampled when req&ready.
REQ-011 imem_rdata  input  32  fetched instruction.
REQ-012 if_id_pc  output  32  PC of instruction in IF/ID.
REQ-013 if_id_instr  output  32  instruction in IF/ID.
REQ-014 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-015 flush_id_ex  output  1  one-cycle pulse killing the ID/EX register on redirect.
REQ-016 misalign_err  output  1  sticky flag, target_pc[1:0]!=0 seen on redirect.

Function
REQ-017 States SHALL be FETCH, HOLD, DRAIN; reset state FETCH.
REQ-018 FETCH: imem_req=1, imem_addr=pc; on imem_ready & !stall & !pc_sel: IF/ID <= {pc, rdata, valid=1}, pc <= pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0).
REQ-019 FETCH, imem_ready & stall & !pc_sel: rdata/pc captured into 1-entry hold buffer, pc <= pc+4, go HOLD; IF/ID unchanged.
REQ-020 FETCH, !imem_ready & stall: IF/ID unchanged, request continues.
REQ-021 HOLD: imem_req=0; when stall=0, IF/ID <= hold buffer, return FETCH.
REQ-022 pc_sel=1 SHALL take priority over stall in every state: pc <= {target_pc[31:2],2'b00}, IF/ID <= {pc_x, NOP_INSTR, valid=0}, flush_id_ex=1 same cycle (combinational from pc_sel), hold buffer discarded.
REQ-023 Redirect in FETCH with imem_ready=1: response discarded, next state FETCH at new pc.
REQ-024 Redirect in FETCH with imem_ready=0 (request outstanding): go DRAIN; DRAIN keeps imem_req=1 at old address until imem_ready, discards that rdata, then FETCH at redirected pc.
REQ-025 Second redirect while in DRAIN SHALL overwrite the pending target; last one wins.
REQ-026 Redirect with target_pc[1:0]!=0 SHALL set misalign_err until reset; fetch proceeds at aligned address.
REQ-027 Fetch latency: with ready=1 every cycle and no stall, one instruction per cycle; first valid IF/ID one cycle after reset release.
REQ-028 IF/ID register and pc SHALL never change in a cycle where stall=1 and pc_sel=0, except capture into hold buffer.

Reset
REQ-029 On rst: pc=RESET_PC, state=FETCH, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, misalign_err=0, hold buffer empty.
REQ-030 imem_req=0 and flush_id_ex=0 while rst=1; reset mid-request abandons it with no DRAIN.

Structure
REQ-031 NOP_INSTR, RESET_PC and the state encoding SHALL live in the shared core package with existing opcode constants.
REQ-032 No sub-module; an optional pc_reg sub-module (pc, pc+4, redirect mux) is permitted.

Verification
REQ-033 Reset release, ready=1 constant -> IF/ID shows pc 0x0,0x4,0x8 on consecutive cycles, valid=1.
REQ-034 stall=1 for 3 cycles mid-stream at pc 0x8 -> IF/ID holds 0x4 entry, HOLD entered, 0x8 delivered the cycle after stall drops, none lost/duplicated.
REQ-035 pc_sel=1, target 0x100, stall=1 same cycle -> flush_id_ex=1, if_id_valid=0, next fetch address 0x100.
REQ-036 pc_sel=1 target 0x200 while request to 0x10 outstanding (ready=0 two cycles) -> imem_addr stays 0x10 until ready, rdata dropped, then imem_addr=0x200.
REQ-037 Redirect to 0x202 -> misalign_err=1, fetch at 0x200, flag persists until rst.
REQ-038 rst asserted during HOLD -> pc=RESET_PC, if_id_valid=0, hold entry discarded.
